// File: rtl/mem_arbiter_pkg.sv
// Shared types, default widths and the grant-selection helper for mem_arbiter.
package mem_arb_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_MAX_WAIT = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // A lone requester is always served.
  // Under contention, the port that was not served last wins.
  function automatic grant_t pick_grant(input logic   i_pend,
                                        input logic   d_pend,
                                        input grant_t last_grant);
    grant_t g;
    if (i_pend && d_pend) begin
      g = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
    end else if (d_pend) begin
      g = GRANT_D;
    end else begin
      g = GRANT_I;
    end
    return g;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (fetch and data), the arbiter and the RAM.
// slave  : the arbiter's view (serves requests, drives the RAM).
// master : the environment's view (CPU ports plus RAM responder).
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ready;

  logic              d_ren;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ren;
  logic              ram_wen;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_busy;

  modport slave (
    input  i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ram_rdata, ram_busy,
    output i_rdata, i_ready, d_rdata, d_ready, ram_addr, ram_wdata, ram_ren, ram_wen
  );

  modport master (
    output i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, ram_rdata, ram_busy,
    input  i_rdata, i_ready, d_rdata, d_ready, ram_addr, ram_wdata, ram_ren, ram_wen
  );

endinterface

// File: rtl/mem_arbiter_wait_timer.sv
// wait_timer: counts busy cycles of one RAM access and flags when the tolerated
// number has been reached. The count saturates at the limit until cleared.
module wait_timer
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int               CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] count;

  assign expired = (count == LIMIT);

  // Busy-cycle counter: cleared between accesses, stops once the limit is hit.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between instruction fetch and data
// load/store. One access at a time: IDLE picks a port and latches its request,
// ACCESS drives the RAM until busy drops (or the wait timer expires), DONE
// pulses the granted port's ready for one cycle.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic         clk,
  input  logic         nRST,
  mem_arbiter_if.slave bus,
  output logic         err
);

  arb_state_t state;
  arb_state_t next_state;

  grant_t last_grant;
  grant_t grant_q;
  grant_t grant_next;

  logic op_write;
  logic write_next;
  logic first_cycle;

  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              ram_ren_q;
  logic              ram_wen_q;

  logic              i_ready_q;
  logic              d_ready_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              err_q;

  logic d_pend;
  logic any_pend;
  logic access_end;
  logic expired;

  logic latch_req;
  logic finish;
  logic timed_out;
  logic timer_en;
  logic timer_clr;
  logic retire;

  // A simultaneous read+write request is handled as a write.
  assign d_pend     = bus.d_ren | bus.d_wen;
  assign any_pend   = bus.i_req | d_pend;
  assign grant_next = pick_grant(bus.i_req, d_pend, last_grant);
  assign write_next = (grant_next == GRANT_D) && bus.d_wen;

  // The RAM needs a cycle to raise busy, so the first ACCESS cycle never ends
  // the access. A low busy takes priority over an expired timer.
  assign access_end = !first_cycle && (!bus.ram_busy || expired);

  wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .nRST    (nRST),
    .clear   (timer_clr),
    .enable  (timer_en),
    .expired (expired)
  );

  // State register; an asserted reset forces IDLE immediately.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: IDLE -> ACCESS on any request, ACCESS -> DONE when the
  // RAM finishes or gives up, DONE -> IDLE unconditionally.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (any_pend) next_state = ACCESS;
      ACCESS:  if (access_end) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Per-state control strobes for the datapath registers and the wait timer.
  always_comb begin
    latch_req = 1'b0;
    finish    = 1'b0;
    timed_out = 1'b0;
    timer_en  = 1'b0;
    timer_clr = 1'b1;
    retire    = 1'b0;
    case (state)
      IDLE: begin
        latch_req = any_pend;
      end
      ACCESS: begin
        timer_clr = 1'b0;
        timer_en  = bus.ram_busy;
        finish    = access_end;
        timed_out = access_end && bus.ram_busy;
      end
      DONE: begin
        retire = 1'b1;
      end
      default: begin
        latch_req = 1'b0;
      end
    endcase
  end

  // Request latch and RAM drive: the granted request is captured once and held
  // stable on the RAM lines until the access ends.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      first_cycle <= 1'b0;
      grant_q     <= GRANT_I;
      op_write    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
    end else begin
      first_cycle <= latch_req;
      if (latch_req) begin
        grant_q     <= grant_next;
        op_write    <= write_next;
        ram_addr_q  <= (grant_next == GRANT_D) ? bus.d_addr : bus.i_addr;
        ram_wdata_q <= write_next ? bus.d_wdata : '0;
        ram_ren_q   <= !write_next;
        ram_wen_q   <= write_next;
      end else if (finish) begin
        ram_ren_q <= 1'b0;
        ram_wen_q <= 1'b0;
      end
    end
  end

  // Completion: load the granted port's data register and raise its ready for
  // the DONE cycle. Writes and aborted accesses return zero.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else if (finish) begin
      if (grant_q == GRANT_I) begin
        i_ready_q <= 1'b1;
        i_rdata_q <= timed_out ? '0 : bus.ram_rdata;
      end else begin
        d_ready_q <= 1'b1;
        d_rdata_q <= (timed_out || op_write) ? '0 : bus.ram_rdata;
      end
    end else if (retire) begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
    end
  end

  // Fairness history and the sticky timeout flag; err clears only on reset.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      last_grant <= GRANT_D;
      err_q      <= 1'b0;
    end else begin
      if (retire) begin
        last_grant <= grant_q;
      end
      if (timed_out) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.ram_ren   = ram_ren_q;
  assign bus.ram_wen   = ram_wen_q;
  assign bus.i_ready   = i_ready_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign err           = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed, table-driven bench for mem_arbiter with a short
// wait limit so timeouts are reachable. Inputs change on the falling edge and
// outputs are sampled there too.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic nRST;
  logic err;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  mem_arbiter #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .MAX_WAIT (MW)
  ) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus.slave),
    .err  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] ram_rdata;
    int          busy_high;
    logic        exp_port_d;
    logic [31:0] exp_addr;
    logic        exp_wen;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic clearInputs();
    bus.i_req     = 1'b0;
    bus.i_addr    = '0;
    bus.d_ren     = 1'b0;
    bus.d_wen     = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.ram_rdata = '0;
    bus.ram_busy  = 1'b0;
  endtask

  task automatic doReset();
    nRST = 1'b0;
    clearInputs();
    repeat (2) @(negedge clk);
    nRST = 1'b1;
  endtask

  // One complete transaction: k counts rising edges from the grant edge (k=0).
  // The RAM model holds busy high for the first busy_high ACCESS cycles.
  task automatic applyStimulus(input vec_t v);
    int          k;
    int          strobe_cycles;
    logic        seen;
    logic        unstable;
    logic        other_ready;
    logic [31:0] got_rdata;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        wen0;
    logic        ren0;
    bus.i_req     = v.i_req;
    bus.i_addr    = v.i_addr;
    bus.d_ren     = v.d_ren;
    bus.d_wen     = v.d_wen;
    bus.d_addr    = v.d_addr;
    bus.d_wdata   = v.d_wdata;
    bus.ram_rdata = v.ram_rdata;
    bus.ram_busy  = 1'b0;
    k = 0; strobe_cycles = 0; seen = 1'b0; unstable = 1'b0; other_ready = 1'b0;
    got_rdata = '0; addr0 = '0; wdata0 = '0; wen0 = 1'b0; ren0 = 1'b0;
    while (!seen && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      if (v.exp_port_d ? bus.d_ready : bus.i_ready) begin
        seen      = 1'b1;
        got_rdata = v.exp_port_d ? bus.d_rdata : bus.i_rdata;
      end else begin
        if (bus.ram_ren || bus.ram_wen) begin
          strobe_cycles++;
          if (strobe_cycles == 1) begin
            addr0 = bus.ram_addr; wdata0 = bus.ram_wdata;
            wen0 = bus.ram_wen; ren0 = bus.ram_ren;
          end else if (bus.ram_addr !== addr0 || bus.ram_wdata !== wdata0 ||
                       bus.ram_wen !== wen0 || bus.ram_ren !== ren0) begin
            unstable = 1'b1;
          end
        end
        bus.ram_busy = ((k + 1) <= v.busy_high);
        k++;
      end
      if (v.exp_port_d ? bus.i_ready : bus.d_ready) other_ready = 1'b1;
    end
    bus.i_req = 1'b0; bus.d_ren = 1'b0; bus.d_wen = 1'b0; bus.ram_busy = 1'b0;
    checkOutput({v.name, ".latency"}, 32'(k), 32'(v.exp_lat));
    checkOutput({v.name, ".rdata"}, got_rdata, v.exp_rdata);
    checkOutput({v.name, ".ram_addr"}, addr0, v.exp_addr);
    checkOutput({v.name, ".ram_wen"}, 32'(wen0), 32'(v.exp_wen));
    checkOutput({v.name, ".ram_ren"}, 32'(ren0), 32'(!v.exp_wen));
    if (v.exp_wen) checkOutput({v.name, ".ram_wdata"}, wdata0, v.exp_wdata);
    checkOutput({v.name, ".strobe_cycles"}, 32'(strobe_cycles), 32'(v.exp_lat));
    checkOutput({v.name, ".strobe_unstable"}, 32'(unstable), 32'd0);
    checkOutput({v.name, ".other_ready"}, 32'(other_ready), 32'd0);
    checkOutput({v.name, ".err"}, 32'(err), 32'(v.exp_err));
    @(posedge clk);
    @(negedge clk);
    checkOutput({v.name, ".ready_width"},
                32'(v.exp_port_d ? bus.d_ready : bus.i_ready), 32'd0);
    checkOutput({v.name, ".rdata_hold"},
                v.exp_port_d ? bus.d_rdata : bus.i_rdata, v.exp_rdata);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] pat;
    int          events;
    int          ev_port[4];
    int          ev_time[4];
    logic [31:0] ev_data[4];
    int          both_ready;
    int          wide_pulse;
    logic        prev_i;
    logic        prev_d;
    int          k;
    logic        seen;

    vecs[0] = '{"fetch_basic", 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0050_0093, 0,
                1'b0, 32'h10, 1'b0, 32'h0, 32'h0050_0093, 2, 1'b0};
    vecs[1] = '{"store_busy3", 1'b0, 32'h0, 1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 32'h9999_9999, 3,
                1'b1, 32'h20, 1'b1, 32'hDEAD_BEEF, 32'h0, 4, 1'b0};
    vecs[2] = '{"load_busy1", 1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 32'h5555_5555, 32'hCAFE_F00D, 1,
                1'b1, 32'h44, 1'b0, 32'h0, 32'hCAFE_F00D, 2, 1'b0};
    vecs[3] = '{"ren_wen_write", 1'b0, 32'h0, 1'b1, 1'b1, 32'h30, 32'h1234_5678, 32'hFFFF_FFFF, 2,
                1'b1, 32'h30, 1'b1, 32'h1234_5678, 32'h0, 3, 1'b0};
    vecs[4] = '{"fetch_busy_limit", 1'b1, 32'h14, 1'b0, 1'b0, 32'h0, 32'h0, 32'h1111_1111, 4,
                1'b0, 32'h14, 1'b0, 32'h0, 32'h1111_1111, 5, 1'b0};
    vecs[5] = '{"fetch_timeout", 1'b1, 32'h18, 1'b0, 1'b0, 32'h0, 32'h0, 32'h2222_2222, 100,
                1'b0, 32'h18, 1'b0, 32'h0, 32'h0, 5, 1'b1};
    vecs[6] = '{"fetch_after_err", 1'b1, 32'h1C, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0A0A_0A0A, 0,
                1'b0, 32'h1C, 1'b0, 32'h0, 32'h0A0A_0A0A, 2, 1'b1};
    vecs[7] = '{"load_timeout", 1'b0, 32'h0, 1'b1, 1'b0, 32'h50, 32'h0, 32'h7777_7777, 100,
                1'b1, 32'h50, 1'b0, 32'h0, 32'h0, 5, 1'b1};

    // Reset values while reset is held.
    nRST = 1'b0;
    clearInputs();
    #3;
    checkOutput("reset.ram_ren", 32'(bus.ram_ren), 32'd0);
    checkOutput("reset.ram_wen", 32'(bus.ram_wen), 32'd0);
    checkOutput("reset.i_ready", 32'(bus.i_ready), 32'd0);
    checkOutput("reset.d_ready", 32'(bus.d_ready), 32'd0);
    checkOutput("reset.err", 32'(err), 32'd0);
    checkOutput("reset.ram_addr", bus.ram_addr, 32'd0);
    checkOutput("reset.i_rdata", bus.i_rdata, 32'd0);
    checkOutput("reset.d_rdata", bus.d_rdata, 32'd0);
    @(negedge clk);
    nRST = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle.no_request_strobe", 32'(bus.ram_ren | bus.ram_wen), 32'd0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
    end

    // Continuous contention from reset: grants alternate I, D, I, D, with a
    // ready every four cycles starting two edges after the first grant.
    doReset();
    pat = 32'hA5A5_0000;
    bus.i_req  = 1'b1;
    bus.i_addr = 32'h100;
    bus.d_ren  = 1'b1;
    bus.d_addr = 32'h200;
    events = 0; both_ready = 0; wide_pulse = 0; prev_i = 1'b0; prev_d = 1'b0;
    for (int c = 0; c < 40 && events < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      bus.ram_rdata = bus.ram_addr ^ pat;
      if (bus.i_ready && bus.d_ready) both_ready++;
      if ((bus.i_ready && prev_i) || (bus.d_ready && prev_d)) wide_pulse++;
      if (bus.i_ready && !prev_i) begin
        ev_port[events] = 0; ev_time[events] = c; ev_data[events] = bus.i_rdata; events++;
      end else if (bus.d_ready && !prev_d) begin
        ev_port[events] = 1; ev_time[events] = c; ev_data[events] = bus.d_rdata; events++;
      end
      prev_i = bus.i_ready;
      prev_d = bus.d_ready;
    end
    bus.i_req = 1'b0;
    bus.d_ren = 1'b0;
    checkOutput("alt.events", 32'(events), 32'd4);
    checkOutput("alt.both_ready", 32'(both_ready), 32'd0);
    checkOutput("alt.wide_pulse", 32'(wide_pulse), 32'd0);
    for (int e = 0; e < events; e++) begin
      checkOutput($sformatf("alt.port%0d", e), 32'(ev_port[e]), 32'(e % 2));
      checkOutput($sformatf("alt.time%0d", e), 32'(ev_time[e]), 32'(2 + 4 * e));
      checkOutput($sformatf("alt.data%0d", e), ev_data[e],
                  ((e % 2) == 0) ? (32'h100 ^ pat) : (32'h200 ^ pat));
    end
    repeat (3) @(negedge clk);

    // Reset during an access: strobes drop at once, no ready pulse, and the
    // first contended grant afterwards goes to the instruction port.
    doReset();
    bus.d_wen   = 1'b1;
    bus.d_addr  = 32'h300;
    bus.d_wdata = 32'hFEED_0001;
    @(posedge clk);
    @(negedge clk);
    bus.ram_busy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstmid.wen_before", 32'(bus.ram_wen), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    checkOutput("rstmid.wen_drop", 32'(bus.ram_wen), 32'd0);
    checkOutput("rstmid.ram_addr", bus.ram_addr, 32'd0);
    checkOutput("rstmid.d_ready", 32'(bus.d_ready), 32'd0);
    bus.ram_busy = 1'b0;
    bus.i_req    = 1'b1;
    bus.i_addr   = 32'h400;
    bus.ram_rdata = 32'h0BAD_CAFE;
    @(negedge clk);
    checkOutput("rstmid.no_ready", 32'(bus.d_ready | bus.i_ready), 32'd0);
    nRST = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstmid.grant_ren", 32'(bus.ram_ren), 32'd1);
    checkOutput("rstmid.grant_wen", 32'(bus.ram_wen), 32'd0);
    checkOutput("rstmid.grant_addr", bus.ram_addr, 32'h400);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (bus.i_ready) seen = 1'b1;
    end
    checkOutput("rstmid.i_latency", 32'(k), 32'd2);
    checkOutput("rstmid.i_rdata", bus.i_rdata, 32'h0BAD_CAFE);
    clearInputs();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
